// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Purpose: data-memory beat handshake between the pipeline controller and
//          the data memory port.
// Signals:
//   dmem_req   controller -> memory  beat request, held until dmem_ack
//   dmem_beat  controller -> memory  word offset of the current beat
//   dmem_ack   memory -> controller  current beat accepted
// Modports: master = controller side, slave = memory side.
interface pipeline_hazard_ctrl_if #(
  parameter int VEC_BEATS = 4
);
  localparam int BEAT_W = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;

  logic              dmem_req;
  logic [BEAT_W-1:0] dmem_beat;
  logic              dmem_ack;

  modport master (output dmem_req, output dmem_beat, input dmem_ack);
  modport slave  (input dmem_req, input dmem_beat, output dmem_ack);
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Purpose: hazard/stall controller for the 5-stage scalar/vector core.
//   - selects EX operand forwarding (MEM result beats WB result)
//   - raises IF/ID/EX/MEM stalls and ID/EX flush + MEM/WB clear strobes
//   - sequences single-beat (scalar) or VEC_BEATS-beat (vector) data-memory
//     accesses over a req/ack handshake, with a sticky timeout fault
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   id_rs1/id_rs2                  source registers of the instruction in ID
//   ex_rs1/ex_rs2/ex_rd            registers of the instruction in EX
//   ex_reg_write, ex_mem_read      EX control bits
//   mem_rd, mem_reg_write,
//   mem_mem_read, mem_mem_write,
//   mem_vector_op                  MEM stage destination/control bits
//   wb_rd, wb_reg_write            WB stage destination/control bits
//   ex_pc_src                      taken branch/jump resolved in EX
//   ex_op1_forward/ex_op2_forward  00 register file, 01 WB, 10 MEM
//   if/id/ex/mem_stall             hold the respective pipeline register
//   id_flush, ex_flush, wb_clear   bubble into IF/ID, ID/EX, MEM/WB
//   mem_fault                      sticky handshake timeout
//   dmem                           data-memory beat handshake (master side)
// All outputs are forced low while reset is asserted.
module pipeline_hazard_ctrl #(
  parameter int VEC_BEATS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       mem_mem_read,
  input  logic       mem_mem_write,
  input  logic       mem_vector_op,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       ex_pc_src,
  output logic [1:0] ex_op1_forward,
  output logic [1:0] ex_op2_forward,
  output logic       if_stall,
  output logic       id_stall,
  output logic       ex_stall,
  output logic       mem_stall,
  output logic       id_flush,
  output logic       ex_flush,
  output logic       wb_clear,
  output logic       mem_fault,
  pipeline_hazard_ctrl_if.master dmem
);

  localparam int BEAT_W = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
  // Counter only has to reach TIMEOUT-1 before the fault is taken.
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(VEC_BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [BEAT_W-1:0] beat_r;
  logic [BEAT_W-1:0] beat_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;

  logic              mem_acc_s;
  logic              load_use_s;
  logic [BEAT_W-1:0] last_beat_s;

  // Pipeline-rule strobes shared by RUN and the DONE release cycle
  logic              hz_if_stall_s;
  logic              hz_id_stall_s;
  logic              hz_id_flush_s;
  logic              hz_ex_flush_s;

  // Pre-reset-gating versions of every output
  logic [1:0]        fwd1_s;
  logic [1:0]        fwd2_s;
  logic              if_stall_s;
  logic              id_stall_s;
  logic              ex_stall_s;
  logic              mem_stall_s;
  logic              id_flush_s;
  logic              ex_flush_s;
  logic              wb_clear_s;
  logic              fault_s;
  logic              req_s;
  logic [BEAT_W-1:0] beat_out_s;

  // ex_reg_write is implied by ex_mem_read for the load-use check
  logic              unused_ex_reg_write_s;
  assign unused_ex_reg_write_s = ex_reg_write;

  // Forward-select for one EX source operand; a load in MEM has no result
  // yet, so it cannot forward and the WB copy (if any) is used instead.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic       mem_wr_en,
    input logic [4:0] mem_dst,
    input logic       mem_is_load,
    input logic       wb_wr_en,
    input logic [4:0] wb_dst
  );
    logic [1:0] sel;
    if (mem_wr_en && (mem_dst != 5'd0) && (mem_dst == rs) && !mem_is_load) begin
      sel = 2'b10;
    end else if (wb_wr_en && (wb_dst != 5'd0) && (wb_dst == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand forwarding and hazard detection terms
  always_comb begin
    fwd1_s      = fwd_select(ex_rs1, mem_reg_write, mem_rd, mem_mem_read, wb_reg_write, wb_rd);
    fwd2_s      = fwd_select(ex_rs2, mem_reg_write, mem_rd, mem_mem_read, wb_reg_write, wb_rd);
    mem_acc_s   = mem_mem_read | mem_mem_write;
    load_use_s  = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    last_beat_s = mem_vector_op ? BEAT_LAST : {BEAT_W{1'b0}};
  end

  // Branch/load-use strobes: a taken branch kills the dependent instruction
  // anyway, so it outranks the load-use stall.
  always_comb begin
    hz_if_stall_s = 1'b0;
    hz_id_stall_s = 1'b0;
    hz_id_flush_s = 1'b0;
    hz_ex_flush_s = 1'b0;
    if (ex_pc_src) begin
      hz_id_flush_s = 1'b1;
      hz_ex_flush_s = 1'b1;
    end else if (load_use_s) begin
      hz_if_stall_s = 1'b1;
      hz_id_stall_s = 1'b1;
      hz_ex_flush_s = 1'b1;
    end else begin
      hz_if_stall_s = 1'b0;
    end
  end

  // State, beat index and timeout counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
      beat_r  <= {BEAT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and raw output decode
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    cnt_nxt_s   = cnt_r;
    if_stall_s  = 1'b0;
    id_stall_s  = 1'b0;
    ex_stall_s  = 1'b0;
    mem_stall_s = 1'b0;
    id_flush_s  = 1'b0;
    ex_flush_s  = 1'b0;
    wb_clear_s  = 1'b0;
    fault_s     = 1'b0;
    req_s       = 1'b0;
    beat_out_s  = {BEAT_W{1'b0}};

    case (state_r)
      ST_RUN: begin
        if (mem_acc_s) begin
          // Freeze the whole pipe this cycle; the request starts next cycle.
          if_stall_s  = 1'b1;
          id_stall_s  = 1'b1;
          ex_stall_s  = 1'b1;
          mem_stall_s = 1'b1;
          wb_clear_s  = 1'b1;
          beat_nxt_s  = {BEAT_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_ACCESS;
        end else begin
          if_stall_s  = hz_if_stall_s;
          id_stall_s  = hz_id_stall_s;
          id_flush_s  = hz_id_flush_s;
          ex_flush_s  = hz_ex_flush_s;
        end
      end

      ST_ACCESS: begin
        // MEM is stalled, so mem_vector_op is stable for the whole burst
        // and later changes of the access strobes cannot restart anything.
        if_stall_s  = 1'b1;
        id_stall_s  = 1'b1;
        ex_stall_s  = 1'b1;
        mem_stall_s = 1'b1;
        wb_clear_s  = 1'b1;
        req_s       = 1'b1;
        beat_out_s  = beat_r;
        if (dmem.dmem_ack) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (beat_r == last_beat_s) begin
            beat_nxt_s  = {BEAT_W{1'b0}};
            state_nxt_s = ST_DONE;
          end else begin
            beat_nxt_s  = beat_r + BEAT_W'(1);
          end
        end else begin
          if (cnt_r == CNT_LIMIT) begin
            state_nxt_s = ST_FAULT;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        // Release cycle: the memory instruction leaves MEM now, so its
        // still-asserted access strobe must not start a second access.
        if_stall_s  = hz_if_stall_s;
        id_stall_s  = hz_id_stall_s;
        id_flush_s  = hz_id_flush_s;
        ex_flush_s  = hz_ex_flush_s;
        state_nxt_s = ST_RUN;
      end

      ST_FAULT: begin
        if_stall_s  = 1'b1;
        id_stall_s  = 1'b1;
        ex_stall_s  = 1'b1;
        mem_stall_s = 1'b1;
        fault_s     = 1'b1;
      end

      default: begin
        state_nxt_s = ST_RUN;
        beat_nxt_s  = {BEAT_W{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output gating: reset forces every output low immediately, which also
  // drops an in-flight request without waiting for a clock edge.
  always_comb begin
    if (reset) begin
      ex_op1_forward = 2'b00;
      ex_op2_forward = 2'b00;
      if_stall       = 1'b0;
      id_stall       = 1'b0;
      ex_stall       = 1'b0;
      mem_stall      = 1'b0;
      id_flush       = 1'b0;
      ex_flush       = 1'b0;
      wb_clear       = 1'b0;
      mem_fault      = 1'b0;
      dmem.dmem_req  = 1'b0;
      dmem.dmem_beat = {BEAT_W{1'b0}};
    end else begin
      ex_op1_forward = fwd1_s;
      ex_op2_forward = fwd2_s;
      if_stall       = if_stall_s;
      id_stall       = id_stall_s;
      ex_stall       = ex_stall_s;
      mem_stall      = mem_stall_s;
      id_flush       = id_flush_s;
      ex_flush       = ex_flush_s;
      wb_clear       = wb_clear_s;
      mem_fault      = fault_s;
      dmem.dmem_req  = req_s;
      dmem.dmem_beat = beat_out_s;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, all compared against a behavioural model built on
// beat/idle counters rather than an explicit state machine.
module tb_pipeline_hazard_ctrl;
  localparam int VEC_BEATS = 4;
  localparam int TIMEOUT   = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, ex_mem_read;
  logic       mem_reg_write, mem_mem_read, mem_mem_write, mem_vector_op;
  logic       wb_reg_write, ex_pc_src;
  logic [1:0] ex_op1_forward, ex_op2_forward;
  logic       if_stall, id_stall, ex_stall, mem_stall;
  logic       id_flush, ex_flush, wb_clear, mem_fault;

  pipeline_hazard_ctrl_if #(.VEC_BEATS(VEC_BEATS)) dmem_if ();

  pipeline_hazard_ctrl #(.VEC_BEATS(VEC_BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_vector_op(mem_vector_op),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_pc_src(ex_pc_src),
    .ex_op1_forward(ex_op1_forward), .ex_op2_forward(ex_op2_forward),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .id_flush(id_flush), .ex_flush(ex_flush), .wb_clear(wb_clear), .mem_fault(mem_fault),
    .dmem(dmem_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: beats still owed, current beat, silent cycles, release flag
  int m_pending   = 0;
  int m_beat      = 0;
  int m_silent    = 0;
  bit m_just_done = 1'b0;
  bit m_faulted   = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs && !mem_mem_read) return 2'b10;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare all outputs against the model for the inputs currently applied
  task automatic check_cycle(input string tag);
    logic [3:0] e_fwd;
    logic [6:0] e_ctl;  // {if,id,ex,mem stall, id_flush, ex_flush, wb_clear}
    logic [3:0] e_mem;  // {req, beat[1:0], fault}
    bit lu;
    e_fwd = 4'h0; e_ctl = 7'h00; e_mem = 4'h0;
    lu = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (!reset) begin
      e_fwd = {fwd_ref(ex_rs1), fwd_ref(ex_rs2)};
      if (m_faulted) begin
        e_ctl = 7'b1111_000; e_mem = 4'b0001;
      end else if (m_pending > 0) begin
        e_ctl = 7'b1111_001; e_mem = {1'b1, 2'(m_beat), 1'b0};
      end else if (!m_just_done && (mem_mem_read || mem_mem_write)) begin
        e_ctl = 7'b1111_001;
      end else if (ex_pc_src) begin
        e_ctl = 7'b0000_110;
      end else if (lu) begin
        e_ctl = 7'b1100_010;
      end
    end
    chk({tag, "/fwd"}, 16'({ex_op1_forward, ex_op2_forward}), 16'(e_fwd));
    chk({tag, "/ctl"}, 16'({if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, wb_clear}), 16'(e_ctl));
    chk({tag, "/mem"}, 16'({dmem_if.dmem_req, dmem_if.dmem_beat, mem_fault}), 16'(e_mem));
  endtask

  // Advance the model over one clock edge using the inputs of that cycle
  task automatic model_edge();
    if (reset) begin
      m_pending = 0; m_beat = 0; m_silent = 0; m_just_done = 1'b0; m_faulted = 1'b0;
    end else if (m_faulted) begin
      m_faulted = 1'b1;
    end else if (m_pending > 0) begin
      if (dmem_if.dmem_ack) begin
        m_silent = 0; m_pending--; m_beat++;
        if (m_pending == 0) begin m_beat = 0; m_just_done = 1'b1; end
      end else begin
        m_silent++;
        if (m_silent == TIMEOUT) m_faulted = 1'b1;
      end
    end else if (m_just_done) begin
      m_just_done = 1'b0;
    end else if (mem_mem_read || mem_mem_write) begin
      m_pending = mem_vector_op ? VEC_BEATS : 1; m_beat = 0; m_silent = 0;
    end
  endtask

  task automatic run_cycle(input string tag);
    #1; check_cycle(tag);
    @(posedge clk); model_edge(); #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_rd = 5'd0; mem_reg_write = 1'b0;
    mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_vector_op = 1'b0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; ex_pc_src = 1'b0; dmem_if.dmem_ack = 1'b0;
  endtask

  initial begin
    int stall_cnt;
    int req_cnt;
    logic [1:0] beats_q[$];

    // Reset with a forwarding match present: outputs must still be 0
    reset = 1'b1; set_idle();
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; ex_pc_src = 1'b1;
    run_cycle("reset0");
    run_cycle("reset1");
    reset = 1'b0; set_idle();
    run_cycle("idle");

    // MEM forward beats WB; rd=0 never forwards
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    #1; chk("t1_op1_mem", 16'(ex_op1_forward), 16'h2);
    run_cycle("t1a");
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    run_cycle("t1b");

    // Load in MEM cannot forward, WB copy used (also starts a scalar access)
    set_idle();
    ex_rs2 = 5'd7; wb_rd = 5'd7; wb_reg_write = 1'b1; mem_rd = 5'd7;
    mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    #1; chk("t2_op2_wb", 16'(ex_op2_forward), 16'h1);
    run_cycle("t2_detect");
    dmem_if.dmem_ack = 1'b1;
    run_cycle("t2_access");
    run_cycle("t2_done");

    // Load-use stall, then branch outranks it
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3;
    #1; chk("t3_lu", 16'({if_stall, id_stall, ex_flush, id_flush}), 16'b1110);
    run_cycle("t3_lu");
    ex_pc_src = 1'b1;
    #1; chk("t3_br", 16'({if_stall, id_stall, ex_flush, id_flush}), 16'b0011);
    run_cycle("t3_br");

    // Scalar load, zero-wait ack: 2 stall cycles, 1 request cycle
    set_idle();
    mem_mem_read = 1'b1; dmem_if.dmem_ack = 1'b1;
    stall_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (if_stall) stall_cnt++; if (dmem_if.dmem_req) req_cnt++;
      run_cycle($sformatf("t4_%0d", i));
    end
    chk("t4_stalls", 16'(stall_cnt), 16'd2);
    chk("t4_reqs", 16'(req_cnt), 16'd1);
    set_idle();
    run_cycle("t4_after");

    // Vector store, ack on every 2nd ACCESS cycle: detect + 8 ACCESS = 9 stalls
    mem_mem_write = 1'b1; mem_vector_op = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      dmem_if.dmem_ack = (i > 0) && (i % 2 == 0);
      #1; if (if_stall) stall_cnt++;
      if (dmem_if.dmem_req && dmem_if.dmem_ack) beats_q.push_back(dmem_if.dmem_beat);
      run_cycle($sformatf("t5_%0d", i));
    end
    chk("t5_stalls", 16'(stall_cnt), 16'd9);
    chk("t5_nbeats", 16'(beats_q.size()), 16'd4);
    foreach (beats_q[k]) chk($sformatf("t5_beat%0d", k), 16'(beats_q[k]), 16'(k));
    set_idle();
    run_cycle("t5_after");

    // Async reset in the middle of a vector access drops the request at once
    mem_mem_write = 1'b1; mem_vector_op = 1'b1; dmem_if.dmem_ack = 1'b1;
    run_cycle("t7_detect");
    run_cycle("t7_beat0");
    reset = 1'b1;
    #1; chk("t7_req_async", 16'(dmem_if.dmem_req), 16'd0);
    run_cycle("t7_rst");
    reset = 1'b0; set_idle();
    run_cycle("t7_after");

    // Timeout: detect + 255 silent ACCESS cycles -> sticky fault
    mem_mem_read = 1'b1;
    for (int i = 0; i < 1 + TIMEOUT + 3; i++) run_cycle($sformatf("t6_%0d", i));
    #1;
    chk("t6_fault", 16'(mem_fault), 16'd1);
    chk("t6_stalls", 16'({if_stall, id_stall, ex_stall, mem_stall, dmem_if.dmem_req}), 16'b11110);
    dmem_if.dmem_ack = 1'b1; mem_mem_read = 1'b0;
    run_cycle("t6_ack_ignored0");
    run_cycle("t6_ack_ignored1");
    reset = 1'b1;
    #1; chk("t6_reset_outs", 16'({ex_op1_forward, ex_op2_forward, if_stall, id_stall, ex_stall,
        mem_stall, id_flush, ex_flush, wb_clear, mem_fault, dmem_if.dmem_req, dmem_if.dmem_beat}), 16'd0);
    run_cycle("t6_rst");
    reset = 1'b0; set_idle();
    run_cycle("t6_after");

    // Randomized traffic; MEM fields frozen while the model says MEM is stalled
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(3, 0)); id_rs2 = 5'($urandom_range(3, 0));
      ex_rs1 = 5'($urandom_range(3, 0)); ex_rs2 = 5'($urandom_range(3, 0));
      ex_rd  = 5'($urandom_range(3, 0));
      ex_reg_write = 1'($urandom_range(1, 0));
      ex_mem_read  = ($urandom_range(3, 0) == 0);
      ex_pc_src    = ($urandom_range(4, 0) == 0);
      wb_rd = 5'($urandom_range(3, 0)); wb_reg_write = 1'($urandom_range(1, 0));
      if (m_pending == 0 && !m_faulted) begin
        mem_rd = 5'($urandom_range(3, 0)); mem_reg_write = 1'($urandom_range(1, 0));
        mem_mem_read  = ($urandom_range(7, 0) == 0);
        mem_mem_write = ($urandom_range(7, 0) == 0);
        mem_vector_op = 1'($urandom_range(1, 0));
      end else begin
        mem_mem_read  = 1'($urandom_range(1, 0));
        mem_mem_write = 1'($urandom_range(1, 0));
      end
      dmem_if.dmem_ack = 1'($urandom_range(1, 0));
      reset = ($urandom_range(299, 0) == 0);
      run_cycle($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
